// File: rtl/cmd_sched_pkg.sv
// cmd_sched_pkg: command codes, response characters, FSM states and the hex encoder shared by the scheduler.
package cmd_sched_pkg;
  localparam logic [3:0] CMD_PING   = 4'd0;
  localparam logic [3:0] CMD_LOAD   = 4'd1;
  localparam logic [3:0] CMD_HASH   = 4'd2;
  localparam logic [3:0] CMD_MINE   = 4'd3;
  localparam logic [3:0] CMD_STATUS = 4'd4;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_H = 8'h48;
  localparam logic [7:0] RSP_F = 8'h46;
  localparam logic [7:0] RSP_X = 8'h58;
  localparam logic [7:0] RSP_S = 8'h53;
  localparam int MAX_RESP_LEN = 65;
  localparam int LEN_W = $clog2(MAX_RESP_LEN);
  typedef enum logic [2:0] {IDLE, DECODE, HASH_START, HASH_WAIT, CHECK, RESP} state_t;
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/command_scheduler_if.sv
// command_scheduler_if: host-command, hash-core and transmitter signals of the scheduler.
//   master: scheduler side (drives hash_start/hash_block, tx_start/tx_byte, busy, dropped)
//   slave : environment side (drives cmd_ready/command/data_count/buffer, hash_done/hash_digest, tx_busy)
interface command_scheduler_if;
  logic         cmd_ready;
  logic [3:0]   command;
  logic [15:0]  data_count;
  logic [255:0] buffer;
  logic         hash_start;
  logic [255:0] hash_block;
  logic         hash_done;
  logic [255:0] hash_digest;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         tx_busy;
  logic         busy;
  logic         dropped;
  modport master (
    input  cmd_ready, command, data_count, buffer, hash_done, hash_digest, tx_busy,
    output hash_start, hash_block, tx_start, tx_byte, busy, dropped
  );
  modport slave (
    output cmd_ready, command, data_count, buffer, hash_done, hash_digest, tx_busy,
    input  hash_start, hash_block, tx_start, tx_byte, busy, dropped
  );
endinterface

// File: rtl/hex_serializer.sv
// hex_serializer: emits a header byte then len ASCII hex nibbles of a left-aligned value, one per next strobe.
//   clk, rst (async active-low); load latches header/value/len; next advances
//   byte_out: current ASCII byte; last: current byte is the final one
module hex_serializer
  import cmd_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             next,
  input  logic [7:0]       header,
  input  logic [255:0]     value,
  input  logic [LEN_W-1:0] len,
  output logic [7:0]       byte_out,
  output logic             last
);
  logic [255:0]     val_q, val_d;
  logic [7:0]       hdr_q, hdr_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  // Index 0 is the header; the value only shifts once body nibbles are being consumed.
  always_comb begin
    val_d = load ? value : (next && idx_q != '0) ? val_q << 4 : val_q;
    hdr_d = load ? header : hdr_q;
    len_d = load ? len : len_q;
    idx_d = load ? '0 : next ? idx_q + LEN_W'(1) : idx_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
      hdr_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      val_q <= val_d;
      hdr_q <= hdr_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end
  assign byte_out = idx_q == '0 ? hdr_q : hex_char(val_q[255:252]);
  assign last = idx_q == len_q;
endmodule

// File: rtl/command_scheduler.sv
// command_scheduler: latches host commands, runs single hashes and nonce searches on the hash core, and serialises ASCII responses.
//   clk, rst (async active-low)
//   bus.master: cmd_ready/command/data_count/buffer in; hash_start/hash_block out, hash_done/hash_digest in;
//               tx_start/tx_byte out, tx_busy in; busy and dropped status out
module command_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int          NONCE_W  = 32,
  parameter logic [31:0] MAX_ITER = 32'hFFFF_FFFF
) (
  input logic                 clk,
  input logic                 rst,
  command_scheduler_if.master bus
);
  state_t             state_q, state_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [15:0]        dc_q, dc_d;
  logic [255:0]       buf_q, buf_d, block_q, block_d, digest_q, digest_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [31:0]        iter_q, iter_d;
  logic               tx_start_q, tx_start_d, last_sent_q, last_sent_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               ser_load, ser_next, ser_last;
  logic [7:0]         ser_hdr, ser_byte;
  logic [255:0]       ser_val, nonce_text;
  logic [LEN_W-1:0]   ser_len;
  logic [8:0]         shamt;
  logic               found, mining;
  assign mining = cmd_q == CMD_MINE;
  assign nonce_text = {32'(nonce_q), 224'b0};
  // Shifting right by 256-D keeps only the top D digest bits; D=0 shifts everything out and always succeeds.
  assign shamt = 9'd256 - {1'b0, dc_q[7:0]};
  assign found = (digest_q >> shamt) == '0;
  assign bus.hash_start = state_q == HASH_START;
  assign bus.hash_block = mining ? {block_q[255:NONCE_W], nonce_q} : block_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_byte = tx_byte_q;
  assign bus.busy = state_q != IDLE;
  assign bus.dropped = bus.cmd_ready && state_q != IDLE;
  hex_serializer u_ser (
    .clk(clk), .rst(rst), .load(ser_load), .next(ser_next), .header(ser_hdr),
    .value(ser_val), .len(ser_len), .byte_out(ser_byte), .last(ser_last)
  );
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    dc_d = dc_q;
    buf_d = buf_q;
    block_d = block_q;
    digest_d = digest_q;
    nonce_d = nonce_q;
    iter_d = iter_q;
    last_sent_d = last_sent_q;
    tx_start_d = 1'b0;
    tx_byte_d = tx_byte_q;
    ser_load = 1'b0;
    ser_next = 1'b0;
    ser_hdr = RSP_E;
    ser_val = '0;
    ser_len = '0;
    case (state_q)
      IDLE: if (bus.cmd_ready) begin
        cmd_d = bus.command;
        dc_d = bus.data_count;
        buf_d = bus.buffer;
        state_d = DECODE;
      end
      DECODE: begin
        ser_load = 1'b1;
        last_sent_d = 1'b0;
        state_d = RESP;
        case (cmd_q)
          CMD_PING: ser_hdr = RSP_K;
          CMD_LOAD: if (dc_q <= 16'd64) begin
            block_d = buf_q;
            ser_hdr = RSP_K;
          end
          CMD_HASH: begin
            ser_load = 1'b0;
            state_d = HASH_START;
          end
          CMD_MINE: begin
            ser_load = 1'b0;
            nonce_d = '0;
            iter_d = '0;
            state_d = HASH_START;
          end
          CMD_STATUS: begin
            ser_hdr = RSP_S;
            ser_val = nonce_text;
            ser_len = LEN_W'(8);
          end
          default: ;
        endcase
      end
      HASH_START: state_d = HASH_WAIT;
      HASH_WAIT: if (bus.hash_done) begin
        digest_d = bus.hash_digest;
        state_d = CHECK;
      end
      CHECK: begin
        ser_load = 1'b1;
        last_sent_d = 1'b0;
        state_d = RESP;
        if (!mining) begin
          ser_hdr = RSP_H;
          ser_val = digest_q;
          ser_len = LEN_W'(64);
        end else if (found) begin
          ser_hdr = RSP_F;
          ser_val = nonce_text;
          ser_len = LEN_W'(8);
        end else if (iter_q == MAX_ITER) begin
          ser_hdr = RSP_X;
        end else begin
          ser_load = 1'b0;
          nonce_d = nonce_q + NONCE_W'(1);
          iter_d = iter_q + 32'd1;
          state_d = HASH_START;
        end
      end
      // tx_busy only rises the cycle after tx_start, so the previous pulse also blocks the next one.
      RESP: if (!bus.tx_busy && !tx_start_q) begin
        if (last_sent_q) state_d = IDLE;
        else begin
          tx_start_d = 1'b1;
          tx_byte_d = ser_byte;
          ser_next = 1'b1;
          last_sent_d = ser_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      dc_q <= '0;
      buf_q <= '0;
      block_q <= '0;
      digest_q <= '0;
      nonce_q <= '0;
      iter_q <= '0;
      last_sent_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      dc_q <= dc_d;
      buf_q <= buf_d;
      block_q <= block_d;
      digest_q <= digest_d;
      nonce_q <= nonce_d;
      iter_q <= iter_d;
      last_sent_q <= last_sent_d;
      tx_start_q <= tx_start_d;
      tx_byte_q <= tx_byte_d;
    end
  end
endmodule

// File: tb/tb_command_scheduler.sv
// tb_command_scheduler: directed and random commands against a string-level response model, with hash-core and UART responders.
module tb_command_scheduler;
  localparam logic [31:0] MAXI = 32'd3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  logic [255:0] hash_blocks[$];
  logic [255:0] exp_blocks[$];
  logic [255:0] digest_plan[$];
  logic [255:0] block_m = '0;
  logic [31:0] nonce_m = '0;
  int hash_wait = 0;
  int tx_left = 0;
  logic [7:0] held = '0;
  logic prev_start = 1'b0;
  string hex_digits = "0123456789ABCDEF";
  command_scheduler_if bus();
  command_scheduler #(.NONCE_W(32), .MAX_ITER(MAXI)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  always @(negedge clk) begin
    bus.hash_done = 1'b0;
    if (!rst) hash_wait = 0;
    else begin
      if (hash_wait > 0) begin
        hash_wait--;
        if (hash_wait == 0) begin
          bus.hash_done = 1'b1;
          bus.hash_digest = digest_plan.size() > 0 ? digest_plan.pop_front() : rand256();
        end
      end
      if (bus.hash_start) begin
        hash_blocks.push_back(bus.hash_block);
        hash_wait = $urandom_range(1, 4);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      tx_left = 0;
      bus.tx_busy = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (tx_left > 0) tx_left--;
      bus.tx_busy = tx_left > 0;
      if (bus.tx_start) begin
        check("tx_gap", 256'({bus.tx_busy, prev_start}), 256'(0));
        rx.push_back(bus.tx_byte);
        held = bus.tx_byte;
        tx_left = $urandom_range(2, 5);
      end else if (bus.tx_busy) check("tx_hold", 256'(bus.tx_byte), 256'(held));
      prev_start = bus.tx_start;
    end
  end
  task automatic push_hex(input logic [255:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(hex_digits[v[255-4*i -: 4]]));
  endtask
  task automatic get_digest(input int k, output logic [255:0] d);
    logic [255:0] r;
    while (digest_plan.size() <= k) begin
      r = rand256();
      if ($urandom_range(0, 1) == 1) r[255:240] = '0;
      digest_plan.push_back(r);
    end
    d = digest_plan[k];
  endtask
  function automatic bit lead_zero(input logic [255:0] d, input int n);
    for (int i = 0; i < n; i++) if (d[255-i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_cmd(input logic [3:0] c, input logic [15:0] dc, input logic [255:0] b);
    logic [255:0] d;
    exp_q.delete();
    exp_blocks.delete();
    if (c == 4'd0) exp_q.push_back("K");
    else if (c == 4'd1) begin
      if (dc > 16'd64) exp_q.push_back("E");
      else begin
        block_m = b;
        exp_q.push_back("K");
      end
    end else if (c == 4'd2) begin
      get_digest(0, d);
      exp_blocks.push_back(block_m);
      exp_q.push_back("H");
      push_hex(d, 64);
    end else if (c == 4'd3) begin
      for (int k = 0; k <= int'(MAXI); k++) begin
        get_digest(k, d);
        exp_blocks.push_back({block_m[255:32], 32'(k)});
        nonce_m = 32'(k);
        if (lead_zero(d, int'(dc[7:0]))) begin
          exp_q.push_back("F");
          push_hex({nonce_m, 224'b0}, 8);
          break;
        end
      end
      if (exp_q.size() == 0) exp_q.push_back("X");
    end else if (c == 4'd4) begin
      exp_q.push_back("S");
      push_hex({nonce_m, 224'b0}, 8);
    end else exp_q.push_back("E");
  endtask
  task automatic start_cmd(input logic [3:0] c, input logic [15:0] dc, input logic [255:0] b);
    rx.delete();
    hash_blocks.delete();
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    bus.command = c;
    bus.data_count = dc;
    bus.buffer = b;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    #1 check("busy_up", 256'(bus.busy), 256'(1));
  endtask
  task automatic finish_cmd(input string tag);
    for (int i = 0; i < 5000 && bus.busy; i++) @(negedge clk);
    check({tag, "_idle"}, 256'(bus.busy), 256'(0));
    check({tag, "_rx_len"}, 256'(rx.size()), 256'(exp_q.size()));
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) check({tag, "_rx_byte"}, 256'(rx[i]), 256'(exp_q[i]));
    check({tag, "_hash_runs"}, 256'(hash_blocks.size()), 256'(exp_blocks.size()));
    for (int i = 0; i < hash_blocks.size() && i < exp_blocks.size(); i++) check({tag, "_hash_block"}, hash_blocks[i], exp_blocks[i]);
    check({tag, "_plan_used"}, 256'(digest_plan.size()), 256'(0));
  endtask
  task automatic run(input string tag, input logic [3:0] c, input logic [15:0] dc, input logic [255:0] b);
    model_cmd(c, dc, b);
    start_cmd(c, dc, b);
    finish_cmd(tag);
  endtask
  task automatic check_outputs_zero(input string tag);
    check({tag, "_hash_start"}, 256'(bus.hash_start), 256'(0));
    check({tag, "_hash_block"}, bus.hash_block, 256'(0));
    check({tag, "_tx_start"}, 256'(bus.tx_start), 256'(0));
    check({tag, "_tx_byte"}, 256'(bus.tx_byte), 256'(0));
    check({tag, "_busy"}, 256'(bus.busy), 256'(0));
    check({tag, "_dropped"}, 256'(bus.dropped), 256'(0));
  endtask
  initial begin
    logic [3:0] c;
    logic [15:0] dc;
    int pick;
    bus.cmd_ready = 1'b0;
    bus.command = '0;
    bus.data_count = '0;
    bus.buffer = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    run("ping", 4'd0, 16'd0, '0);
    run("load16", 4'd1, 16'd16, 256'h0123456789ABCDEF);
    digest_plan.push_back(256'hABCDEF0123456789_FEDCBA9876543210_0011223344556677_8899AABBCCDDEE00);
    run("hash", 4'd2, 16'd0, '0);
    for (int k = 0; k < 3; k++) digest_plan.push_back({8'(k + 1), 248'(rand256())});
    digest_plan.push_back({8'h00, 248'(rand256())});
    run("mine_found", 4'd3, 16'h0008, '0);
    for (int k = 0; k <= int'(MAXI); k++) digest_plan.push_back({8'h80, 248'(rand256())});
    run("mine_exhaust", 4'd3, 16'h0008, '0);
    run("status", 4'd4, 16'd0, '0);
    digest_plan.push_back(rand256());
    model_cmd(4'd2, 16'd0, '0);
    start_cmd(4'd2, 16'd0, '0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (!bus.hash_start && hash_blocks.size() > 0) break;
    end
    bus.command = 4'd0;
    bus.cmd_ready = 1'b1;
    #1 check("dropped_pulse", 256'(bus.dropped), 256'(1));
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    #1 check("dropped_clear", 256'(bus.dropped), 256'(0));
    finish_cmd("drop_hash");
    run("unknown", 4'd9, 16'd0, '0);
    run("load65", 4'd1, 16'd65, rand256());
    digest_plan.push_back(rand256());
    run("hash_after_bad_load", 4'd2, 16'd0, '0);
    run("load64", 4'd1, 16'd64, rand256());
    digest_plan.push_back(rand256());
    model_cmd(4'd2, 16'd0, '0);
    start_cmd(4'd2, 16'd0, '0);
    for (int i = 0; i < 3000 && rx.size() < 11; i++) begin
      @(negedge clk);
      #1;
    end
    check("abort_at_byte", 256'(rx.size()), 256'(11));
    rst = 1'b0;
    #1 check_outputs_zero("abort");
    repeat (3) @(negedge clk);
    check("abort_no_resend", 256'(rx.size()), 256'(11));
    rst = 1'b1;
    block_m = '0;
    nonce_m = '0;
    digest_plan.delete();
    run("ping_after_abort", 4'd0, 16'd0, '0);
    run("status_after_abort", 4'd4, 16'd0, '0);
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 6);
      c = pick == 5 ? 4'($urandom_range(5, 15)) : pick == 6 ? 4'd1 : 4'(pick);
      dc = c == 4'd1 ? 16'($urandom_range(0, 80)) : c == 4'd3 ? {8'($urandom), 8'($urandom_range(0, 12))} : 16'($urandom);
      run("random", c, dc, rand256());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
